// File: rtl/alu_64.sv
// Registered LEGv8-style integer ALU: the combinational core computes the result
// and NZCV flags, and they are captured one clock after an accepted operation.
module alu_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic [WIDTH-1:0] F,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             out_valid
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH:0]   sum;
    logic             c_res;
    logic             v_res;

    // ADD and SUB share one adder; SUB feeds ~B with a carry-in of 1.
    always_comb begin
        b_eff    = (Op == OP_SUB) ? ~B : B;
        carry_in = (Op == OP_SUB);
        sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    end

    always_comb begin
        res   = '0;
        c_res = 1'b0;
        v_res = 1'b0;
        case (Op)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_ADD, OP_SUB: begin
                res   = sum[WIDTH-1:0];
                c_res = sum[WIDTH];
                v_res = (A[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_PASS: res = B;
            OP_NOR:  res = ~(A | B);
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F         <= '0;
            Z         <= 1'b1;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                F <= res;
                Z <= (res == '0);
                N <= res[WIDTH-1];
                C <= c_res;
                V <= v_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: vector table driven through a scoreboard queue,
// plus hand sequences for idle-cycle hold and asynchronous reset mid-stream.
module tb_alu_64;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Op;
    logic [W-1:0] F;
    logic         Z, N, C, V, out_valid;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic         z, n, c, v;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];
    vec_t exp_q[$];
    vec_t last_exp;
    vec_t rst_rec;
    logic exp_ov;
    int   checks = 0;
    int   errors = 0;

    alu_64 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .Op(Op),
        .F(F), .Z(Z), .N(N), .C(C), .V(V), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] f, input logic z, input logic n,
                                input logic c, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.f = f; t.z = z; t.n = n; t.c = c; t.v = v;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, " F"}, F, last_exp.f);
        chk({tag, " Z"}, {63'd0, Z}, {63'd0, last_exp.z});
        chk({tag, " N"}, {63'd0, N}, {63'd0, last_exp.n});
        chk({tag, " C"}, {63'd0, C}, {63'd0, last_exp.c});
        chk({tag, " V"}, {63'd0, V}, {63'd0, last_exp.v});
    endtask

    task automatic check_out();
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        if (exp_ov) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected pending result");
            end else begin
                last_exp = exp_q.pop_front();
            end
            chk_flags("result");
        end else begin
            chk_flags("hold");
        end
    endtask

    task automatic step(input logic iv, input vec_t t);
        @(negedge clk);
        check_out();
        in_valid = iv;
        A        = t.a;
        B        = t.b;
        Op       = t.op;
        if (iv) exp_q.push_back(t);
        exp_ov = iv;
    endtask

    initial begin
        tbl[0]  = mk(4'b0000, 64'd0, 64'd265, 64'd0, 1, 0, 0, 0);
        tbl[1]  = mk(4'b0001, 64'd9, 64'd564, 64'd573, 0, 0, 0, 0);
        tbl[2]  = mk(4'b0000, 64'd7, 64'd844, 64'd4, 0, 0, 0, 0);
        tbl[3]  = mk(4'b1100, 64'd1, 64'd654, 64'hFFFF_FFFF_FFFF_FD70, 0, 1, 0, 0);
        tbl[4]  = mk(4'b1100, 64'd4, 64'd894, 64'hFFFF_FFFF_FFFF_FC81, 0, 1, 0, 0);
        tbl[5]  = mk(4'b0010, 64'd4, 64'd788, 64'd792, 0, 0, 0, 0);
        tbl[6]  = mk(4'b0110, 64'd6, 64'd549, 64'hFFFF_FFFF_FFFF_FDE1, 0, 1, 0, 0);
        tbl[7]  = mk(4'b0110, 64'd5, 64'd5, 64'd0, 1, 0, 1, 0);
        tbl[8]  = mk(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 0, 1);
        tbl[9]  = mk(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 1, 0);
        tbl[10] = mk(4'b0111, 64'd2, 64'd567, 64'd567, 0, 0, 0, 0);
        tbl[11] = mk(4'b1111, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 64'd0, 1, 0, 0, 0);
        tbl[12] = mk(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0);
        tbl[13] = mk(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
        tbl[14] = mk(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 1, 0, 0, 0);
        tbl[15] = mk(4'b0001, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0001, 0, 1, 0, 0);
        rst_rec = mk(4'b0000, 64'd0, 64'd0, 64'd0, 1, 0, 0, 0);

        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Op       = '0;
        exp_ov   = 1'b0;
        last_exp = rst_rec;
        #1;
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk_flags("reset");
        #12 rst = 1'b0;

        for (int i = 0; i < NV; i++) step(1'b1, tbl[i]);

        // Valid pattern 1,0,1: idle cycle carries junk operands that must be ignored.
        step(1'b1, tbl[1]);
        step(1'b0, tbl[13]);
        step(1'b1, tbl[3]);
        step(1'b0, tbl[8]);
        step(1'b0, tbl[8]);

        // Asynchronous reset right after a result has been loaded.
        step(1'b1, tbl[15]);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
        exp_q.delete();
        exp_ov   = 1'b0;
        last_exp = rst_rec;
        chk_flags("async rst");
        @(negedge clk);
        chk("rst held out_valid", {63'd0, out_valid}, 64'd0);
        chk_flags("rst held");
        in_valid = 1'b0;
        #2 rst = 1'b0;

        step(1'b1, tbl[10]);
        step(1'b1, tbl[8]);
        step(1'b0, tbl[0]);
        step(1'b0, tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
